// File: rtl/latch_stage_skid.sv
// Inter-stage pipeline latch carrying ir, NUM_OPS operands and an rStatus word/flag.
// Valid/ready handshake through a 2-entry skid buffer, with flush and a saturating stall counter.
module latch_stage_skid #(
    parameter int unsigned    W       = 32,
    parameter int unsigned    NUM_OPS = 2,
    parameter logic [W-1:0]   NOP_IR  = 32'h00000000,
    parameter int unsigned    CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         ir_in,
    input  logic [NUM_OPS*W-1:0] ops_in,
    input  logic                 isRStatus_in,
    input  logic [W-1:0]         rStatus_in,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         ir_out,
    output logic [NUM_OPS*W-1:0] ops_out,
    output logic                 isRStatus_out,
    output logic [W-1:0]         rStatus_out,

    output logic [CNT_W-1:0]     stall_count
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StMain  = 2'd1,
        StBoth  = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   in_ready_q, in_ready_d;

    // Main entry drives the outputs; skid entry absorbs the one in-flight word
    // accepted while downstream stalls.
    logic [W-1:0]         main_ir_q;
    logic [NUM_OPS*W-1:0] main_ops_q;
    logic                 main_isr_q;
    logic [W-1:0]         main_rs_q;

    logic [W-1:0]         skid_ir_q;
    logic [NUM_OPS*W-1:0] skid_ops_q;
    logic                 skid_isr_q;
    logic [W-1:0]         skid_rs_q;

    logic [CNT_W-1:0]     stall_q, stall_d;

    logic acc;
    logic deq;
    logic main_from_in;
    logic main_from_skid;
    logic skid_from_in;
    logic skid_clear;

    assign out_valid = (state_q != StEmpty);
    assign in_ready  = in_ready_q;
    assign acc       = in_valid & in_ready_q;
    assign deq       = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_from_in   = 1'b0;
        main_from_skid = 1'b0;
        skid_from_in   = 1'b0;
        skid_clear     = 1'b0;

        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (acc) begin
                        state_d      = StMain;
                        main_from_in = 1'b1;
                    end
                end
                StMain: begin
                    if (acc && deq) begin
                        main_from_in = 1'b1;
                    end else if (acc) begin
                        state_d      = StBoth;
                        skid_from_in = 1'b1;
                    end else if (deq) begin
                        state_d = StEmpty;
                    end
                end
                StBoth: begin
                    if (deq) begin
                        state_d        = StMain;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end

        // Registered ready: depends only on next state, never on out_ready directly.
        in_ready_d = (state_d != StBoth);
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            stall_q    <= stall_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            main_ir_q  <= NOP_IR;
            main_ops_q <= '0;
            main_isr_q <= 1'b0;
            main_rs_q  <= '0;
        end else if (main_from_in) begin
            main_ir_q  <= ir_in;
            main_ops_q <= ops_in;
            main_isr_q <= isRStatus_in;
            main_rs_q  <= rStatus_in;
        end else if (main_from_skid) begin
            main_ir_q  <= skid_ir_q;
            main_ops_q <= skid_ops_q;
            main_isr_q <= skid_isr_q;
            main_rs_q  <= skid_rs_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || skid_clear) begin
            skid_ir_q  <= NOP_IR;
            skid_ops_q <= '0;
            skid_isr_q <= 1'b0;
            skid_rs_q  <= '0;
        end else if (skid_from_in) begin
            skid_ir_q  <= ir_in;
            skid_ops_q <= ops_in;
            skid_isr_q <= isRStatus_in;
            skid_rs_q  <= rStatus_in;
        end
    end

    // Bubble values mask any stale payload left behind by a flush or dequeue.
    always_comb begin
        ir_out        = NOP_IR;
        ops_out       = '0;
        isRStatus_out = 1'b0;
        rStatus_out   = '0;
        if (out_valid) begin
            ir_out        = main_ir_q;
            ops_out       = main_ops_q;
            isRStatus_out = main_isr_q;
            rStatus_out   = main_rs_q;
        end
    end

    assign stall_count = stall_q;

endmodule

// File: tb/tb_latch_stage_skid.sv
// Directed bench for latch_stage_skid: two instances share stimulus, one with CNT_W=2
// to exercise counter saturation.
module tb_latch_stage_skid;

    localparam int unsigned  W      = 32;
    localparam int unsigned  NOPS   = 2;
    localparam logic [31:0]  NOP    = 32'h0000_0013;

    logic              clock = 1'b0;
    logic              reset, flush, in_valid, out_ready, isr_in;
    logic [W-1:0]      ir_in, rs_in;
    logic [NOPS*W-1:0] ops_in;

    logic              in_ready, out_valid, isr_out;
    logic [W-1:0]      ir_out, rs_out;
    logic [NOPS*W-1:0] ops_out;
    logic [15:0]       stall16;

    logic              in_ready2, out_valid2, isr_out2;
    logic [W-1:0]      ir_out2, rs_out2;
    logic [NOPS*W-1:0] ops_out2;
    logic [1:0]        stall2;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    latch_stage_skid #(.W(W), .NUM_OPS(NOPS), .NOP_IR(NOP), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .ir_in(ir_in), .ops_in(ops_in),
        .isRStatus_in(isr_in), .rStatus_in(rs_in),
        .out_valid(out_valid), .out_ready(out_ready), .ir_out(ir_out), .ops_out(ops_out),
        .isRStatus_out(isr_out), .rStatus_out(rs_out), .stall_count(stall16)
    );

    latch_stage_skid #(.W(W), .NUM_OPS(NOPS), .NOP_IR(NOP), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .ir_in(ir_in), .ops_in(ops_in),
        .isRStatus_in(isr_in), .rStatus_in(rs_in),
        .out_valid(out_valid2), .out_ready(out_ready), .ir_out(ir_out2), .ops_out(ops_out2),
        .isRStatus_out(isr_out2), .rStatus_out(rs_out2), .stall_count(stall2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        isr_in    = 1'b0;
        ir_in     = '0;
        rs_in     = '0;
        ops_in    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic offer(input logic [31:0] ir, input logic [31:0] rs, input logic isr);
        in_valid = 1'b1;
        ir_in    = ir;
        rs_in    = rs;
        isr_in   = isr;
        ops_in   = {ir ^ 32'h0000_00F0, ir ^ 32'h0000_000F};
    endtask

    initial begin
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_ir_bubble", ir_out, NOP);
        check("rst_ops_zero", ops_out, 0);
        check("rst_stall", stall16, 0);

        // 1: streaming with out_ready held high
        in_valid  = 1'b1;
        ir_in     = 32'h00A1_0005;
        ops_in    = {32'h11, 32'h22};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_out_valid", out_valid, 1);
            check("t1_ir", ir_out, 32'h00A1_0005);
            check("t1_ops", ops_out, {32'h11, 32'h22});
            check("t1_in_ready", in_ready, 1);
            check("t1_stall", stall16, 0);
        end
        in_valid = 1'b0;
        tick();
        check("t1_drain_valid", out_valid, 0);
        check("t1_drain_ir", ir_out, NOP);

        // 2: fill both entries under back-pressure, then drain in order
        do_reset();
        offer(32'hA, 32'h0, 1'b0);
        tick();
        check("t2_a_main_ir", ir_out, 32'hA);
        check("t2_a_in_ready", in_ready, 1);
        offer(32'hB, 32'h0, 1'b0);
        tick();
        check("t2_both_in_ready", in_ready, 0);
        check("t2_both_ir", ir_out, 32'hA);
        check("t2_both_ops", ops_out, {32'hFA, 32'h5});
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("t2_deq_b_valid", out_valid, 1);
        check("t2_deq_b_ir", ir_out, 32'hB);
        check("t2_deq_b_in_ready", in_ready, 1);
        tick();
        check("t2_empty_valid", out_valid, 0);
        check("t2_empty_ir", ir_out, NOP);
        check("t2_empty_ops", ops_out, 0);

        // 3: stall counting and saturation at CNT_W=2
        do_reset();
        offer(32'h33, 32'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("t3_stall_start", stall16, 0);
        for (int i = 0; i < 5; i++) tick();
        check("t3_stall16_5", stall16, 5);
        check("t3_stall2_sat", stall2, 3);
        tick();
        check("t3_stall16_6", stall16, 6);
        check("t3_stall2_hold", stall2, 3);

        // 4: flush while full, with accept and dequeue offered in the same cycle
        do_reset();
        offer(32'hA, 32'h1234, 1'b1);
        tick();
        offer(32'hB, 32'h5678, 1'b0);
        tick();
        check("t4_full_in_ready", in_ready, 0);
        check("t4_full_rs", rs_out, 32'h1234);
        flush     = 1'b1;
        out_ready = 1'b1;
        offer(32'hC, 32'h9, 1'b1);
        tick();
        check("t4_flush_valid", out_valid, 0);
        check("t4_flush_ir", ir_out, NOP);
        check("t4_flush_in_ready", in_ready, 1);
        check("t4_flush_rs", rs_out, 0);
        check("t4_flush_isr", isr_out, 0);
        check("t4_flush_stall", stall16, 1);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("t4_after_valid", out_valid, 0);

        // 5: rStatus flag lives for exactly one valid cycle
        do_reset();
        out_ready = 1'b1;
        offer(32'h55, 32'h0000_0001, 1'b1);
        tick();
        check("t5_isr_set", isr_out, 1);
        check("t5_rs_set", rs_out, 1);
        in_valid = 1'b0;
        isr_in   = 1'b0;
        tick();
        check("t5_isr_clear", isr_out, 0);
        check("t5_rs_clear", rs_out, 0);

        // 6: reset mid-transfer, then 1-cycle latency again
        do_reset();
        offer(32'h66, 32'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check("t6_pre_stall", stall16, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_stall", stall16, 0);
        out_ready = 1'b1;
        offer(32'h77, 32'h0, 1'b0);
        tick();
        check("t6_lat_valid", out_valid, 1);
        check("t6_lat_ir", ir_out, 32'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
